// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from imem, feeds IF/ID with a one-entry skid buffer.
// Optional bubble counter enabled by defining FETCH_BUBBLE_CNT_EN; otherwise bubble_cnt_o is tied to 0.
module fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_data_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] adder_o,
    output logic              valid_o,
    output logic [31:0]       bubble_cnt_o
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] drain_addr, drain_addr_n;
    logic [31:0]       instr, instr_n;
    logic [ADDR_W-1:0] adder, adder_n;
    logic              valid, valid_n;
    logic [31:0]       skid_instr, skid_instr_n;
    logic [ADDR_W-1:0] skid_adder, skid_adder_n;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic              unused_addr_bits;

    assign pc_inc           = pc + ADDR_W'(4);
    assign target           = {branch_addr_i[ADDR_W-1:2], 2'b00};
    assign unused_addr_bits = ^branch_addr_i[1:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drain_addr <= '0;
            instr      <= '0;
            adder      <= '0;
            valid      <= 1'b0;
            skid_instr <= '0;
            skid_adder <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            drain_addr <= drain_addr_n;
            instr      <= instr_n;
            adder      <= adder_n;
            valid      <= valid_n;
            skid_instr <= skid_instr_n;
            skid_adder <= skid_adder_n;
        end
    end

    // Redirect wins over stall and over a same-cycle ack; an unacked request must be drained.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        drain_addr_n = drain_addr;
        instr_n      = instr;
        adder_n      = adder;
        valid_n      = valid;
        skid_instr_n = skid_instr;
        skid_adder_n = skid_adder;
        if (branch_i) begin
            pc_n         = target;
            instr_n      = '0;
            valid_n      = 1'b0;
            skid_instr_n = '0;
            skid_adder_n = '0;
            case (state)
                FETCH: begin
                    if (imem_ack_i) begin
                        state_n = FETCH;
                    end else begin
                        state_n      = DRAIN;
                        drain_addr_n = pc;
                    end
                end
                HOLD:    state_n = FETCH;
                DRAIN:   state_n = DRAIN;
                default: state_n = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack_i) begin
                        pc_n = pc_inc;
                        if (stall_i) begin
                            skid_instr_n = imem_data_i;
                            skid_adder_n = pc_inc;
                            state_n      = HOLD;
                        end else begin
                            instr_n = imem_data_i;
                            adder_n = pc_inc;
                            valid_n = 1'b1;
                        end
                    end else if (!stall_i) begin
                        instr_n = '0;
                        valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        instr_n      = skid_instr;
                        adder_n      = skid_adder;
                        valid_n      = 1'b1;
                        skid_instr_n = '0;
                        skid_adder_n = '0;
                        state_n      = FETCH;
                    end
                end
                DRAIN: begin
                    instr_n = '0;
                    valid_n = 1'b0;
                    if (imem_ack_i) begin
                        state_n = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

    // The request is gated by reset so it drops the moment reset asserts.
    assign imem_req_o  = rst_i && (state != HOLD);
    assign imem_addr_o = (state == DRAIN) ? drain_addr : pc;
    assign instr_o     = instr;
    assign adder_o     = adder;
    assign valid_o     = valid;

`ifdef FETCH_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt <= '0;
        end else if (!valid_n && !stall_i && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt_o = bubble_cnt;
`else
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: expected IF/ID words go into a scoreboard queue,
// a monitor pops and compares each time a new valid instruction is presented.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] instr_o;
    logic [31:0] adder_o;
    logic        valid_o;
    logic [31:0] bubble_cnt_o;

    int tests_run = 0;
    int fail_cnt  = 0;
    logic [63:0] exp_q[$];

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0100)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .branch_i(branch_i),
        .branch_addr_i(branch_addr_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i), .instr_o(instr_o),
        .adder_o(adder_o), .valid_o(valid_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] exp_bub(input logic [31:0] n);
`ifdef FETCH_BUBBLE_CNT_EN
        return n;
`else
        return 32'd0 & n;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] adder);
        exp_q.push_back({instr, adder});
    endtask

    // Drive one cycle of inputs from a negedge, return at the next negedge.
    task automatic step(input logic ack, input logic [31:0] data, input logic stall,
                        input logic branch, input logic [31:0] baddr);
        imem_ack_i    = ack;
        imem_data_i   = data;
        stall_i       = stall;
        branch_i      = branch;
        branch_addr_i = baddr;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        stall_i    = 1'b0;
        branch_i   = 1'b0;
    endtask

    // A non-stalled edge that leaves valid_o high always presents a new instruction.
    initial begin
        logic        stall_s;
        logic [63:0] e;
        forever begin
            @(posedge clk_i);
            stall_s = stall_i;
            #1;
            if (valid_o && !stall_s) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fail_cnt++;
                    $display("[TB] FAIL unexpected_output: got instr 0x%08h adder 0x%08h, expected none",
                             instr_o, adder_o);
                end else begin
                    e = exp_q.pop_front();
                    if (instr_o !== e[63:32] || adder_o !== e[31:0]) begin
                        fail_cnt++;
                        $display("[TB] FAIL sb_output: got instr 0x%08h adder 0x%08h, expected instr 0x%08h adder 0x%08h",
                                 instr_o, adder_o, e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i = 1'b0; stall_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
        imem_ack_i = 1'b0; imem_data_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_adder", adder_o, 32'd0);
        check("rst_bubble", bubble_cnt_o, 32'd0);
        rst_i = 1'b1;
        #1;
        check("start_req", {31'd0, imem_req_o}, 32'd1);
        check("start_addr", imem_addr_o, 32'h100);

        // zero-wait memory, data = address
        for (int i = 0; i < 3; i++) begin
            check("zw_addr", imem_addr_o, 32'h100 + 32'(4 * i));
            push_exp(32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i));
            step(1'b1, imem_addr_o, 1'b0, 1'b0, 32'd0);
            check("zw_valid", {31'd0, valid_o}, 32'd1);
        end

        // two wait cycles per fetch
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
            check("ws_valid0", {31'd0, valid_o}, 32'd0);
            step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
            check("ws_valid1", {31'd0, valid_o}, 32'd0);
            check("ws_addr", imem_addr_o, 32'h10C + 32'(4 * i));
            push_exp(32'h10C + 32'(4 * i), 32'h110 + 32'(4 * i));
            step(1'b1, imem_addr_o, 1'b0, 1'b0, 32'd0);
            check("ws_valid2", {31'd0, valid_o}, 32'd1);
        end
        check("ws_bubble", bubble_cnt_o, exp_bub(32'd6));

        // stall with ack at 0x200
        step(1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h1FC);
        check("st_branch_addr", imem_addr_o, 32'h1FC);
        push_exp(32'h1111_1111, 32'h200);
        step(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'd0);
        check("st_pre_addr", imem_addr_o, 32'h200);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("st_hold_req", {31'd0, imem_req_o}, 32'd0);
            check("st_hold_instr", instr_o, 32'h1111_1111);
            check("st_hold_adder", adder_o, 32'h200);
            check("st_hold_valid", {31'd0, valid_o}, 32'd1);
            if (i < 2) step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        end
        push_exp(32'hDEAD_BEEF, 32'h204);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("st_rel_instr", instr_o, 32'hDEAD_BEEF);
        check("st_rel_adder", adder_o, 32'h204);
        check("st_rel_addr", imem_addr_o, 32'h204);
        check("st_rel_req", {31'd0, imem_req_o}, 32'd1);
        check("st_bubble", bubble_cnt_o, exp_bub(32'd7));

        // branch to 0x3FF while request outstanding at 0x40
        step(1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h40);
        check("dr_pre_addr", imem_addr_o, 32'h40);
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'h3FF);
        check("dr_addr0", imem_addr_o, 32'h40);
        check("dr_req0", {31'd0, imem_req_o}, 32'd1);
        check("dr_valid0", {31'd0, valid_o}, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("dr_addr1", imem_addr_o, 32'h40);
        step(1'b1, 32'hBAD0_0040, 1'b0, 1'b0, 32'd0);
        check("dr_valid2", {31'd0, valid_o}, 32'd0);
        check("dr_instr2", instr_o, 32'd0);
        check("dr_next_addr", imem_addr_o, 32'h3FC);
        check("dr_bubble", bubble_cnt_o, exp_bub(32'd11));

        // branch and stall together
        push_exp(32'h3FC, 32'h400);
        step(1'b1, imem_addr_o, 1'b0, 1'b0, 32'd0);
        check("bs_pre_valid", {31'd0, valid_o}, 32'd1);
        step(1'b1, 32'h7777_7777, 1'b1, 1'b1, 32'h80);
        check("bs_valid", {31'd0, valid_o}, 32'd0);
        check("bs_instr", instr_o, 32'd0);
        check("bs_addr", imem_addr_o, 32'h80);
        check("bs_bubble", bubble_cnt_o, exp_bub(32'd11));

        // PC wrap at the top of the address space
        step(1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'hFFFF_FFFF);
        check("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
        push_exp(32'hCAFE_F00D, 32'h0);
        step(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'd0);
        check("wr_adder", adder_o, 32'h0);
        check("wr_next_addr", imem_addr_o, 32'h0);

        // reset mid-wait at 0x500
        step(1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h500);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("rm_addr", imem_addr_o, 32'h500);
        check("rm_req", {31'd0, imem_req_o}, 32'd1);
        check("rm_bubble", bubble_cnt_o, exp_bub(32'd14));
        #2;
        rst_i = 1'b0;
        #1;
        check("rm_req_async", {31'd0, imem_req_o}, 32'd0);
        check("rm_valid_async", {31'd0, valid_o}, 32'd0);
        check("rm_bubble_async", bubble_cnt_o, 32'd0);
        @(negedge clk_i);
        check("rm_req_held", {31'd0, imem_req_o}, 32'd0);
        rst_i = 1'b1;
        #1;
        check("rm_restart_addr", imem_addr_o, 32'h100);
        check("rm_restart_req", {31'd0, imem_req_o}, 32'd1);
        push_exp(32'h100, 32'h104);
        step(1'b1, imem_addr_o, 1'b0, 1'b0, 32'd0);
        check("rm_restart_valid", {31'd0, valid_o}, 32'd1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
